// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage conditional-branch resolver.
// S1 registers the {V,C,N,Z} flags of rs1 - rs2 together with funct3, the
// prediction and the tag; S2 turns the flags into the taken/mispredict/illegal
// result and holds it until the consumer takes it.
// Optional feature macro: BRANCH_STATS_EN adds saturating 32-bit counters of
// delivered taken branches and delivered mispredictions.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic             in_pred_taken,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_taken_cnt,
    output logic [31:0]      stat_mispred_cnt
`endif
);

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    // Stage state
    logic             s1_valid;
    logic [2:0]       s1_funct3;
    logic             s1_pred;
    logic [TAG_W-1:0] s1_tag;
    flags_t           s1_flags;
    logic             s2_valid;

    logic             s1_adv;
    logic             s2_adv;
    logic [XLEN:0]    diff;
    flags_t           in_flags;
    logic             eval_taken;
    logic             eval_illegal;

    // Pipeline advance: a stage may load when it is empty or its content leaves.
    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = s2_valid;

    // Zero-extended subtraction; the extra top bit is the borrow out.
    assign diff = {1'b0, in_rs1} - {1'b0, in_rs2};

    // Flag extraction from the XLEN-bit difference.
    always_comb begin
        in_flags.z = (diff[XLEN-1:0] == '0);
        in_flags.n = diff[XLEN-1];
        in_flags.c = ~diff[XLEN];
        in_flags.v = (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]) & (diff[XLEN-1] ^ in_rs1[XLEN-1]);
    end

    // S1 register: flush wins over any load; payload only moves with a handshake.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state here is written with <= so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_funct3 <= '0;
            s1_pred   <= 1'b0;
            s1_tag    <= '0;
            s1_flags  <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (in_valid && s1_adv) begin
                s1_funct3 <= in_funct3;
                s1_pred   <= in_pred_taken;
                s1_tag    <= in_tag;
                s1_flags  <= in_flags;
            end
        end
    end

    // Branch condition evaluation from the registered flags.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned, which would otherwise infer a latch.
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        case (s1_funct3)
            F_BEQ:   eval_taken = s1_flags.z;
            F_BNE:   eval_taken = ~s1_flags.z;
            F_BLT:   eval_taken = s1_flags.n ^ s1_flags.v;
            F_BGE:   eval_taken = ~(s1_flags.n ^ s1_flags.v);
            F_BLTU:  eval_taken = ~s1_flags.c;
            F_BGEU:  eval_taken = s1_flags.c;
            default: eval_illegal = 1'b1;
        endcase
    end

    // S2 register: result is held unchanged while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid       <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_tag        <= '0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_adv) begin
                out_taken      <= eval_taken;
                out_mispredict <= eval_taken ^ s1_pred;
                out_illegal    <= eval_illegal;
                out_tag        <= s1_tag;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating statistics; a delivery in a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken_cnt   <= '0;
            stat_mispred_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            if (out_taken && (stat_taken_cnt != 32'hFFFF_FFFF)) begin
                stat_taken_cnt <= stat_taken_cnt + 32'd1;
            end
            if (out_mispredict && (stat_mispred_cnt != 32'hFFFF_FFFF)) begin
                stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand width in bits, legal range 8..64.
REQ-002 Parameter TAG_W, default 4: width of the instruction tag carried through the pipeline.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a request is presented.
REQ-006 in_ready  output  1  the unit accepts the request this cycle.
REQ-007 in_funct3  input  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-008 in_rs1, in_rs2  input  XLEN  compare operands.
REQ-009 in_pred_taken  input  1  front-end prediction for this branch.
REQ-010 in_tag  input  TAG_W  opaque instruction tag.
REQ-011 flush  input  1  pipeline kill.
REQ-012 out_valid  output  1  a result is presented.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_taken, out_mispredict, out_illegal  output  1 each  resolved direction; out_taken differs from the prediction; unsupported funct3.
REQ-015 out_tag  output  TAG_W  tag of the resolved request.
REQ-016 stat_taken_cnt, stat_mispred_cnt  output  32 each  statistics counters; present only with BRANCH_STATS_EN.

Function
REQ-017 Two stages, S1 (operand/flag) and S2 (result), each with its own valid bit.
REQ-018 Input handshake when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-019 S2 advance: ~s2_valid | out_ready. S1 advance: ~s1_valid | S2 advance. in_ready = S1 advance; purely combinational, with no path from in_valid.
REQ-020 On an input handshake, S1 registers funct3, pred_taken, tag and flags {V,C,N,Z} from the XLEN-bit rs1 - rs2.
REQ-021 Flag definitions: Z = (difference == 0); N = difference MSB; C = 1 when rs1 >= rs2 unsigned (no borrow); V = signed overflow of the subtraction.
REQ-022 S2 evaluates from the registered flags: 000 Z; 001 ~Z; 100 N^V; 101 ~(N^V); 110 ~C; 111 C.
REQ-023 funct3 010 and 011: out_illegal = 1, out_taken = 0, out_mispredict = in_pred_taken.
REQ-024 out_mispredict = out_taken ^ pred_taken.
REQ-025 Latency: result at out_valid exactly 2 cycles after the input handshake when not stalled.
REQ-026 Throughput: one request per cycle when out_ready stays high.
REQ-027 Back-pressure: while out_valid & ~out_ready, all out_* signals hold stable.
REQ-028 Back-pressure: S1 holds and in_ready = 0 when S1 is also full.
REQ-029 flush: s1_valid and s2_valid clear at the next edge.
REQ-030 flush: an input handshake in the same cycle is discarded.
REQ-031 flush: the output handshake in the same cycle still counts.
REQ-032 flush has priority over all stage loads.
REQ-033 Operands of XLEN-1 bits never appear; all arithmetic is XLEN + 1 bits internally for the borrow.

Reset
REQ-034 rst clears s1_valid and s2_valid immediately.
REQ-035 Output reset values: out_valid = 0; out_taken, out_mispredict, out_illegal = 0; out_tag = 0.
REQ-036 Counter reset values: both counters = 0.
REQ-037 Reset mid-operation drops all in-flight requests, none is ever presented.
REQ-038 in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-039 Macro BRANCH_STATS_EN defined: stat_taken_cnt increments on each output handshake with out_taken = 1.
REQ-040 Macro BRANCH_STATS_EN defined: stat_mispred_cnt increments on each output handshake with out_mispredict = 1.
REQ-041 Both counters saturate at 32'hFFFFFFFF.
REQ-042 Illegal requests count toward mispredict only when out_mispredict = 1.
REQ-043 Without the macro, the stat ports and counters are absent; all other behaviour is identical.

Verification
REQ-044 XLEN = 32, out_ready = 1: BLT rs1 = 0xFFFFFFFF, rs2 = 1 -> cycle 2: out_valid = 1, out_taken = 1; same operands with BLTU -> out_taken = 0.
REQ-045 BGE rs1 = 0x80000000, rs2 = 1 (overflow case) -> out_taken = 0. BEQ rs1 = rs2 = 5 with pred_taken = 0 -> out_taken = 1, out_mispredict = 1.
REQ-046 Back-to-back requests with out_ready = 0 for 3 cycles -> in_ready = 0 after 2 accepts, out_* stable; release -> both results delivered in order with correct tags.
REQ-047 funct3 = 010, pred_taken = 1 -> out_illegal = 1, out_taken = 0, out_mispredict = 1.
REQ-048 Two requests in flight, flush asserted together with a new in_valid -> next cycle out_valid = 0, nothing further emerges.
REQ-049 Counter test with BRANCH_STATS_EN: 3 taken of 5 handshakes -> stat_taken_cnt = 3. rst asserted mid-stream -> out_valid = 0 and counters = 0 immediately, without waiting for a clock edge.
